// File: rtl/writeback_stage.sv
// Final pipeline stage: selects the result source, drives the registered
// register-file write bus and output port, and serializes SWAP into two writes.
module writeback_stage (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        valid,
    input  logic        flush,
    input  logic        wb,
    input  logic        mem_to_reg,
    input  logic        in_op,
    input  logic        out_op,
    input  logic        swap,
    input  logic [15:0] alu_result,
    input  logic [15:0] alu_result2,
    input  logic [15:0] mem_data,
    input  logic [15:0] in_data,
    input  logic [2:0]  rdst_addr,
    input  logic [2:0]  rsrc_addr,
    output logic [19:0] writeback,
    output logic [15:0] out_port,
    output logic        stall_o
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned WB_W   = DATA_W + ADDR_W + 1;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        SWAP2  = 1'b1
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   hold_data;
    logic [ADDR_W-1:0]   hold_addr;
    logic [DATA_W-1:0]   sel_data_c;
    logic                accept_c;

    // Result source select: input port beats memory beats ALU
    always_comb begin
        sel_data_c = alu_result;
        if (in_op) begin
            sel_data_c = in_data;
        end else if (mem_to_reg) begin
            sel_data_c = mem_data;
        end
    end

    assign accept_c = (state == NORMAL) && valid && !flush;

    // Stall is a pure decode of the state register, so it stays input-independent
    assign stall_o = (state == SWAP2);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= NORMAL;
            writeback <= WB_W'(0);
            out_port  <= DATA_W'(0);
            hold_data <= DATA_W'(0);
            hold_addr <= ADDR_W'(0);
        end else begin
            case (state)
                NORMAL: begin
                    writeback <= WB_W'(0);
                    if (accept_c) begin
                        if (out_op) begin
                            out_port <= alu_result;
                        end
                        if (wb && swap) begin
                            writeback <= {1'b1, alu_result, rdst_addr};
                            hold_data <= alu_result2;
                            hold_addr <= rsrc_addr;
                            state     <= SWAP2;
                        end else if (wb) begin
                            writeback <= {1'b1, sel_data_c, rdst_addr};
                        end
                    end
                end
                SWAP2: begin
                    // Second SWAP write; every input, flush included, is ignored here
                    writeback <= {1'b1, hold_data, hold_addr};
                    state     <= NORMAL;
                end
                default: begin
                    writeback <= WB_W'(0);
                    state     <= NORMAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with hand-computed expected bus values.
module tb_writeback_stage;

    logic        Clk;
    logic        Rst;
    logic        valid, flush, wb, mem_to_reg, in_op, out_op, swap;
    logic [15:0] alu_result, alu_result2, mem_data, in_data;
    logic [2:0]  rdst_addr, rsrc_addr;
    logic [19:0] writeback;
    logic [15:0] out_port;
    logic        stall_o;

    int errors = 0;
    int checks = 0;

    writeback_stage dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .valid       (valid),
        .flush       (flush),
        .wb          (wb),
        .mem_to_reg  (mem_to_reg),
        .in_op       (in_op),
        .out_op      (out_op),
        .swap        (swap),
        .alu_result  (alu_result),
        .alu_result2 (alu_result2),
        .mem_data    (mem_data),
        .in_data     (in_data),
        .rdst_addr   (rdst_addr),
        .rsrc_addr   (rsrc_addr),
        .writeback   (writeback),
        .out_port    (out_port),
        .stall_o     (stall_o)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic w, input logic m2r,
                         input logic inp, input logic outp, input logic sw,
                         input logic [15:0] alu, input logic [15:0] alu2,
                         input logic [15:0] mem, input logic [15:0] ind,
                         input logic [2:0] rd, input logic [2:0] rs);
        valid = v; flush = f; wb = w; mem_to_reg = m2r; in_op = inp; out_op = outp;
        swap = sw; alu_result = alu; alu_result2 = alu2; mem_data = mem; in_data = ind;
        rdst_addr = rd; rsrc_addr = rs;
    endtask

    task automatic bubble();
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst = 1'b0;
        bubble();
        #3;
        check("reset_wb", writeback, 20'h0);
        check("reset_out", 20'(out_port), 20'h0);
        check("reset_stall", 20'(stall_o), 20'h0);
        step();
        Rst = 1'b1;
        step();

        // ALU write then bubble
        drive(1, 0, 1, 0, 0, 0, 0, 16'h1234, 16'h0, 16'h0, 16'h0, 3'd5, 3'd0);
        step();
        check("alu_write", writeback, 20'h891A5);
        bubble();
        step();
        check("bubble", writeback, 20'h0);

        // Source priority
        drive(1, 0, 1, 1, 1, 0, 0, 16'h0000, 16'h0, 16'h5555, 16'hAAAA, 3'd2, 3'd0);
        step();
        check("prio_in", writeback, {1'b1, 16'hAAAA, 3'd2});
        in_op = 1'b0;
        step();
        check("prio_mem", writeback, {1'b1, 16'h5555, 3'd2});

        // Accepted without wb writes nothing
        drive(1, 0, 0, 0, 0, 0, 0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 3'd7, 3'd0);
        step();
        check("no_wb", writeback, 20'h0);

        // SWAP with a held follower and flush during SWAP2
        drive(1, 0, 1, 0, 0, 0, 1, 16'h0011, 16'h0022, 16'h0, 16'h0, 3'd1, 3'd3);
        step();
        check("swap_w1", writeback, 20'h80089);
        check("swap_stall1", 20'(stall_o), 20'h1);
        drive(1, 1, 1, 0, 0, 0, 0, 16'h0044, 16'h0, 16'h0, 16'h0, 3'd4, 3'd0);
        step();
        check("swap_w2", writeback, 20'h80113);
        check("swap_stall2", 20'(stall_o), 20'h0);
        flush = 1'b0;
        step();
        check("swap_held", writeback, 20'h80224);
        bubble();
        step();
        check("swap_after", writeback, 20'h0);
        check("swap_stall3", 20'(stall_o), 20'h0);

        // SWAP onto one register, then a back-to-back SWAP
        drive(1, 0, 1, 0, 0, 0, 1, 16'h00A1, 16'h00B2, 16'h0, 16'h0, 3'd6, 3'd6);
        step();
        check("same_w1", writeback, {1'b1, 16'h00A1, 3'd6});
        drive(1, 0, 1, 0, 0, 0, 1, 16'h0C01, 16'h0D02, 16'h0, 16'h0, 3'd0, 3'd7);
        step();
        check("same_w2", writeback, {1'b1, 16'h00B2, 3'd6});
        step();
        check("b2b_w1", writeback, {1'b1, 16'h0C01, 3'd0});
        check("b2b_stall", 20'(stall_o), 20'h1);
        bubble();
        step();
        check("b2b_w2", writeback, {1'b1, 16'h0D02, 3'd7});

        // OUT port capture and flush suppression
        drive(1, 0, 0, 0, 0, 1, 0, 16'hBEEF, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
        step();
        check("out_cap", 20'(out_port), 20'h0BEEF);
        drive(1, 1, 1, 0, 0, 1, 0, 16'hCAFE, 16'h0, 16'h0, 16'h0, 3'd1, 3'd0);
        step();
        check("out_flush", 20'(out_port), 20'h0BEEF);
        check("flush_wb", writeback, 20'h0);
        drive(0, 0, 0, 0, 0, 1, 0, 16'h1111, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
        step();
        check("out_bubble", 20'(out_port), 20'h0BEEF);

        // Reset during SWAP2 abandons the second write
        drive(1, 0, 1, 0, 0, 0, 1, 16'h0055, 16'h0066, 16'h0, 16'h0, 3'd2, 3'd3);
        step();
        check("rswap_w1", writeback, {1'b1, 16'h0055, 3'd2});
        bubble();
        #2;
        Rst = 1'b0;
        #1;
        check("rswap_wb", writeback, 20'h0);
        check("rswap_out", 20'(out_port), 20'h0);
        check("rswap_stall", 20'(stall_o), 20'h0);
        step();
        Rst = 1'b1;
        step();
        check("rswap_nowrite", writeback, 20'h0);
        check("rswap_stall2", 20'(stall_o), 20'h0);
        drive(1, 0, 1, 0, 0, 0, 0, 16'h0777, 16'h0, 16'h0, 16'h0, 3'd7, 3'd0);
        step();
        check("rswap_next", writeback, {1'b1, 16'h0777, 3'd7});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the 5-stage RISC core and the producer end of the 20-bit writeback bus consumed by the decode stage's register file. It captures the MEM/WB entry each cycle and selects the result source (ALU, memory, input port). It drives a registered single-port register-file write, latches the output port for OUT. SWAP is serialized into two consecutive register writes, and the upstream pipeline is stalled for one cycle.

## Interface
Parameters:
- none

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Rst  in  1  asynchronous, active-low reset
- valid  in  1  MEM/WB entry is a real instruction (0 = bubble)
- flush  in  1  kill the entry presented this cycle
- wb  in  1  instruction writes a register
- mem_to_reg  in  1  result comes from memory (LDD, POP)
- in_op  in  1  result comes from input port (IN)
- out_op  in  1  OUT instruction
- swap  in  1  SWAP: two register writes
- alu_result  in  16  ALU result; first SWAP value; OUT value
- alu_result2  in  16  second SWAP value (old Rdst)
- mem_data  in  16  memory read data
- in_data  in  16  sampled input-port value
- rdst_addr  in  3  first destination register
- rsrc_addr  in  3  second SWAP destination register
- writeback  out  20  [19] write enable, [18:3] data, [2:0] register address
- out_port  out  16  output-port register
- stall_o  out  1  hold MEM/WB upstream this cycle

## Operation
- Entry accepted at an edge when state is NORMAL, valid=1, flush=0. Otherwise the edge produces a bubble: writeback = 20'h0.
- Source select, priority order: in_op selects in_data; else mem_to_reg selects mem_data; else alu_result.
- Accepted, wb=1, swap=0: writeback <= {1, selected data, rdst_addr}.
- Accepted, wb=0: writeback <= 0. Data and address are forced to 0 whenever the enable bit is 0.
- Accepted, wb=1, swap=1: writeback <= {1, alu_result, rdst_addr}; state -> SWAP2.
- SWAP2: all inputs are ignored, including flush. Next edge drives writeback <= {1, held alu_result2, held rsrc_addr}; state -> NORMAL.
- alu_result2 and rsrc_addr are captured into internal holding registers on SWAP acceptance.
- rsrc_addr == rdst_addr still takes two writes; the second value wins.
- Accepted out_op: out_port <= alu_result. Otherwise out_port holds. OUT on a flushed or bubble entry does not update it.
- FSM: NORMAL, SWAP2. NORMAL->SWAP2 only on accepted SWAP with wb=1. SWAP2->NORMAL unconditionally after one cycle.
- stall_o = (state == SWAP2).

## Timing
- Reset (Rst=0, asynchronous): writeback=0, out_port=0, stall_o=0, state=NORMAL, holding registers=0. Reset during SWAP2 abandons the second write.
- Latency: inputs sampled at edge N appear on writeback after edge N. The register file writes them at edge N+1.
- SWAP sequence:
  - Edge E1: first write; stall_o rises.
  - Edge E2: second write; stall_o falls.
  - The instruction presented during E1–E2 is held upstream and is accepted at E3.
- No combinational path from any input to any output.
- Back-to-back SWAPs take 2 cycles each, with no gap cycles beyond the stall.

## Test plan
- Reset: Rst=0 mid-run → writeback=0, out_port=0, stall_o=0 immediately, without waiting for Clk.
- ALU write: valid=1, wb=1, alu_result=16'h1234, rdst_addr=5 → next cycle writeback = {1,16'h1234,3'd5}. A following bubble cycle gives writeback=0.
- Source priority: in_op=1, mem_to_reg=1, in_data=16'hAAAA, mem_data=16'h5555, rdst_addr=2 → writeback data 16'hAAAA. Repeat with in_op=0 → 16'h5555.
- SWAP: alu_result=16'h0011, rdst=1, alu_result2=16'h0022, rsrc=3; entry X (wb, rdst=4, 16'h0044) follows and is held.
  - Writes appear on consecutive cycles: {1,0011,1}, then {1,0022,3}, then {1,0044,4}.
  - stall_o is high exactly one cycle.
  - flush=1 during the SWAP2 cycle leaves the second write intact.
- Flush/OUT: out_op=1, alu_result=16'hBEEF accepted → out_port=16'hBEEF. Next OUT with 16'hCAFE and flush=1 → out_port stays 16'hBEEF, writeback=0.
- Reset mid-SWAP: assert Rst=0 during SWAP2 → no second write; after release, stall_o=0 and the next entry is accepted normally.
